// File: rtl/ov7670_cfg_pkg.sv
// Shared types, constants and the power-up register table for the OV7670 SCCB configurator.
package ov7670_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAMRST,
        S_PWRWAIT,
        S_FETCH,
        S_DELAY,
        S_XFER,
        S_GAP,
        S_DONE
    } cfg_state_e;

    localparam logic [15:0] CFG_DELAY = 16'hFFF0;
    localparam logic [15:0] CFG_END   = 16'hFFFF;

    localparam logic [7:0] REG_COM7   = 8'h12;
    localparam logic [7:0] REG_RGB444 = 8'h8C;
    localparam logic [7:0] REG_COM15  = 8'h40;

    // Soft reset, settle, then RGB444 output (xRGB / GGGGBBBB bytes).
    function automatic logic [15:0] cfg_table(input logic [7:0] idx);
        case (idx)
            8'd0:    return {REG_COM7, 8'h80};
            8'd1:    return CFG_DELAY;
            8'd2:    return {REG_COM7, 8'h04};
            8'd3:    return {REG_RGB444, 8'h02};
            8'd4:    return {REG_COM15, 8'hD0};
            default: return CFG_END;
        endcase
    endfunction

endpackage

// File: rtl/sccb_write_master.sv
// One 3-byte SCCB write (START, 27 bits, STOP) paced by a quarter-bit tick.
// Optional SCCB_ACK_CHECK_EN samples SIOD on each 9th bit and aborts with STOP on NACK.
module sccb_write_master #(
    parameter int Q = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic [23:0] word,
    input  logic        siod_in,
    output logic        sioc,
    output logic        siod_oe,
    output logic        ready,
    output logic        nack
);

    localparam logic [6:0] LAST_Q = 7'd119;
    localparam logic [6:0] STOP_Q = 7'd112;

    logic        busy_q, busy_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [6:0]  qidx_q, qidx_d, qidx_nxt;
    logic [23:0] word_q, word_d;
    logic        nack_q, nack_d;
    logic        sioc_q, sioc_d;
    logic        oe_q, oe_d;
    logic        tick;

    // Quarter k of the 120-quarter frame -> {sioc, siod_oe}.
    function automatic logic [1:0] quarter_out(input logic [6:0] k, input logic [23:0] w);
        int          kk, b, p, byi, bp;
        logic [23:0] sh;
        logic [1:0]  r;
        kk = int'(k);
        r  = 2'b10;
        if (kk == 3) begin
            r = 2'b11;
        end else if (kk >= 4 && kk < 112) begin
            b    = (kk - 4) / 4;
            p    = (kk - 4) % 4;
            byi  = b / 9;
            bp   = b % 9;
            sh   = w << (byi * 8 + bp);
            r[1] = (p >= 2);
            r[0] = (bp == 8) ? 1'b0 : ~sh[23];
        end else if (kk >= 112 && kk < 114) begin
            r = 2'b01;
        end else if (kk == 114) begin
            r = 2'b11;
        end
        return r;
    endfunction

`ifdef SCCB_ACK_CHECK_EN
    function automatic logic is_ack_sample(input logic [6:0] k);
        int kk;
        kk = int'(k) - 4;
        return (kk >= 0) && (kk < 108) && (kk % 4 == 3) && ((kk / 4) % 9 == 8);
    endfunction
`else
    logic unused_siod;
    assign unused_siod = siod_in;
`endif

    assign tick = busy_q && (tcnt_q == 16'(Q - 1));

    always_comb begin
        busy_d   = busy_q;
        tcnt_d   = tcnt_q;
        qidx_d   = qidx_q;
        qidx_nxt = qidx_q + 7'd1;
        word_d   = word_q;
        nack_d   = nack_q;
        sioc_d   = sioc_q;
        oe_d     = oe_q;
        if (!busy_q) begin
            if (go) begin
                busy_d           = 1'b1;
                tcnt_d           = '0;
                qidx_d           = '0;
                word_d           = word;
                nack_d           = 1'b0;
                {sioc_d, oe_d}   = quarter_out(7'd0, word);
            end
        end else if (tick) begin
            tcnt_d = '0;
            if (qidx_q == LAST_Q) begin
                busy_d = 1'b0;
                sioc_d = 1'b1;
                oe_d   = 1'b0;
            end else begin
`ifdef SCCB_ACK_CHECK_EN
                if (is_ack_sample(qidx_q) && siod_in) begin
                    nack_d   = 1'b1;
                    qidx_nxt = STOP_Q;
                end
`endif
                qidx_d         = qidx_nxt;
                {sioc_d, oe_d} = quarter_out(qidx_nxt, word_q);
            end
        end else begin
            tcnt_d = tcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            tcnt_q <= '0;
            qidx_q <= '0;
            word_q <= '0;
            nack_q <= 1'b0;
            sioc_q <= 1'b1;
            oe_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            tcnt_q <= tcnt_d;
            qidx_q <= qidx_d;
            word_q <= word_d;
            nack_q <= nack_d;
            sioc_q <= sioc_d;
            oe_q   <= oe_d;
        end
    end

    assign sioc    = sioc_q;
    assign siod_oe = oe_q;
    assign ready   = ~busy_q;
    assign nack    = nack_q;

endmodule

// File: rtl/ov7670_sccb_config.sv
// OV7670 power-up sequencer: camera reset pulse, then table walk over SCCB.
// Define SCCB_ACK_CHECK_EN to abort the run with err on a NACK.
module ov7670_sccb_config
    import ov7670_cfg_pkg::*;
#(
    parameter int         CLK_HZ       = 50_000_000,
    parameter int         SCCB_HZ      = 100_000,
    parameter logic [7:0] DEV_ADDR     = 8'h42,
    parameter int         RST_CYCLES   = 50_000,
    parameter int         DELAY_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       sioc,
    output logic       siod_oe,
    input  logic       siod_in,
    output logic       cam_rst_n,
    output logic       cam_pwdn,
    output logic [7:0] index
);

    localparam int Q          = CLK_HZ / (4 * SCCB_HZ);
    localparam int GAP_CYCLES = 4 * Q;

    cfg_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  index_q, index_d;
    logic [15:0] entry_q;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic        go, m_ready, m_nack;
    logic [23:0] word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        index_d = index_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        go      = 1'b0;
        word    = {DEV_ADDR, entry_q};
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_CAMRST;
                end
            end
            S_CAMRST: begin
                if (cnt_q == 32'(RST_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_PWRWAIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_PWRWAIT: begin
                if (cnt_q == 32'(RST_CYCLES - 1)) begin
                    cnt_d   = '0;
                    index_d = '0;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_FETCH: begin
                // Entry 255 is never executed: a table without an end marker stops there.
                if (entry_q == CFG_END || index_q == 8'hFF) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (entry_q == CFG_DELAY) begin
                    cnt_d   = '0;
                    state_d = S_DELAY;
                end else begin
                    go      = 1'b1;
                    state_d = S_XFER;
                end
            end
            S_DELAY: begin
                if (cnt_q == 32'(DELAY_CYCLES - 1)) begin
                    cnt_d   = '0;
                    index_d = index_q + 8'd1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_XFER: begin
                if (m_ready) begin
                    if (m_nack) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        index_d = index_q + 8'd1;
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == 32'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Table lookup follows index_d so FETCH sees the entry for the index it just entered with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            index_q <= '0;
            entry_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            index_q <= index_d;
            entry_q <= cfg_table(index_d);
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    sccb_write_master #(.Q(Q)) u_master (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (go),
        .word    (word),
        .siod_in (siod_in),
        .sioc    (sioc),
        .siod_oe (siod_oe),
        .ready   (m_ready),
        .nack    (m_nack)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign index     = index_q;
    assign cam_rst_n = (state_q != S_CAMRST);
    assign cam_pwdn  = 1'b0;

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Self-checking bench for ov7670_sccb_config: bus-level decoder plus a table-walk reference model.
module tb_ov7670_sccb_config;

    localparam int CLK_HZ  = 1_600_000;
    localparam int SCCB_HZ = 100_000;
    localparam int Q       = 4;
    localparam int RST_C   = 20;
    localparam int DLY_C   = 100;
    localparam int BOUND   = 20000;

    logic       clk = 1'b0;
    logic       rst_n, start, cam_nack;
    logic       busy, done, err, sioc, siod_oe, siod_in, cam_rst_n, cam_pwdn;
    logic [7:0] index;

    always #5 clk = ~clk;

    assign siod_in = siod_oe ? 1'b0 : cam_nack;

    ov7670_sccb_config #(
        .CLK_HZ(CLK_HZ), .SCCB_HZ(SCCB_HZ), .DEV_ADDR(8'h42),
        .RST_CYCLES(RST_C), .DELAY_CYCLES(DLY_C)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .sioc(sioc), .siod_oe(siod_oe), .siod_in(siod_in), .cam_rst_n(cam_rst_n),
        .cam_pwdn(cam_pwdn), .index(index)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=[%0d..%0d]", name, act, lo, hi);
        end
    endtask

    // ---------------- reference model: expected writes from the register table ----------------
    logic [15:0] tb_table [6] = '{16'h1280, 16'hFFF0, 16'h1204, 16'h8C02, 16'h40D0, 16'hFFFF};
    logic [23:0] exp_words [$];
    bit          delay_before [$];
    int          exp_end_idx;

    task automatic build_model();
        bit pend = 0;
        exp_end_idx = 255;
        for (int i = 0; i < 6; i++) begin
            if (tb_table[i] == 16'hFFFF) begin
                exp_end_idx = i;
                break;
            end
            if (tb_table[i] == 16'hFFF0) begin
                pend = 1;
            end else begin
                exp_words.push_back({8'h42, tb_table[i]});
                delay_before.push_back(pend);
                pend = 0;
            end
        end
    endtask

    // ---------------- bus monitor ----------------
    typedef struct { int nbits; logic [23:0] data; } frame_t;
    frame_t frames [$];
    int     start_times [$], stop_rise_times [$], first_fall_times [$], rst_lens [$];
    int     cyc = 0, nbits = 0, n_start = 0, n_stop = 0, n_camrst = 0, rst_len = 0;
    int     proto_err = 0, timing_err = 0, edge_err = 0, t_start = 0, t_last_rise = 0;
    logic   psioc = 1'b1, psiod = 1'b1, pbusy = 1'b0, pdone = 1'b0, prst = 1'b1;
    logic   siod_now, in_frame = 1'b0, ff_pend = 1'b0;
    logic [23:0] sh = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_frame = 1'b0; nbits = 0; psioc = 1'b1; psiod = 1'b1;
            pbusy = 1'b0; pdone = 1'b0; prst = 1'b1; rst_len = 0;
        end else begin
            siod_now = ~siod_oe;
            if (!cam_rst_n) begin
                if (prst) n_camrst++;
                rst_len++;
            end else if (!prst) begin
                rst_lens.push_back(rst_len);
                rst_len = 0;
            end
            prst = cam_rst_n;
            if (done && busy) edge_err++;
            if (done && !pdone && !(pbusy && !busy)) edge_err++;
            pbusy = busy; pdone = done;
            if (psioc && sioc && siod_now != psiod) begin
                if (!siod_now) begin
                    if (in_frame) proto_err++;
                    in_frame = 1'b1; nbits = 0; sh = '0; n_start++;
                    start_times.push_back(cyc); t_start = cyc; ff_pend = 1'b1;
                end else begin
                    if (!in_frame) proto_err++;
                    n_stop++;
                    frames.push_back('{nbits, sh});
                    stop_rise_times.push_back(t_last_rise);
                    in_frame = 1'b0;
                end
            end
            if (!psioc && sioc) begin
                if (siod_now != psiod) proto_err++;
                if (in_frame) begin
                    if (nbits > 0 && nbits < 27 && (cyc - t_last_rise) != 4 * Q) timing_err++;
                    if (nbits < 27 && nbits % 9 != 8) sh = {sh[22:0], siod_now};
                    nbits++;
                end
                t_last_rise = cyc;
            end
            if (psioc && !sioc && in_frame && ff_pend) begin
                ff_pend = 1'b0;
                if (cyc - t_start != Q) timing_err++;
                first_fall_times.push_back(cyc);
            end
            psioc = sioc; psiod = siod_now;
        end
    end

    task automatic clear_mon();
        frames.delete(); start_times.delete(); stop_rise_times.delete();
        first_fall_times.delete(); rst_lens.delete();
        n_start = 0; n_stop = 0; n_camrst = 0; proto_err = 0; timing_err = 0; edge_err = 0;
    endtask

    // ---------------- output vector tables ----------------
    typedef struct { string name; int sel; logic [7:0] exp; } vec_t;
    vec_t rv [$];
    vec_t dv [$];

    function automatic logic [7:0] get_sig(input int sel);
        case (sel)
            0: return {7'd0, busy};
            1: return {7'd0, done};
            2: return {7'd0, err};
            3: return index;
            4: return {7'd0, sioc};
            5: return {7'd0, siod_oe};
            6: return {7'd0, cam_rst_n};
            default: return {7'd0, cam_pwdn};
        endcase
    endfunction

    task automatic check_vec(input string tag, input vec_t v [$]);
        foreach (v[i]) chk({tag, "_", v[i].name}, 32'(get_sig(v[i].sel)), 32'(v[i].exp));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < BOUND && busy; i++) @(negedge clk);
        chk({name, "_terminates"}, 32'(busy), 32'd0);
    endtask

    task automatic check_run(input string tag);
        int w;
        chk({tag, "_camrst_count"}, 32'(n_camrst), 32'd1);
        chk({tag, "_camrst_len"}, (rst_lens.size() > 0) ? 32'(rst_lens[0]) : 32'hFFFFFFFF, 32'(RST_C));
        chk({tag, "_n_start"}, 32'(n_start), 32'(exp_words.size()));
        chk({tag, "_n_stop"}, 32'(n_stop), 32'(exp_words.size()));
        foreach (exp_words[i]) begin
            if (i < frames.size()) begin
                chk($sformatf("%s_word%0d", tag, i), 32'(frames[i].data), 32'(exp_words[i]));
                chk($sformatf("%s_bits%0d", tag, i), 32'(frames[i].nbits), 32'd28);
            end else begin
                chk($sformatf("%s_word%0d_missing", tag, i), 32'(frames.size()), 32'(i + 1));
            end
        end
        chk({tag, "_proto_err"}, 32'(proto_err), 32'd0);
        chk({tag, "_timing_err"}, 32'(timing_err), 32'd0);
        chk({tag, "_busy_done_edge"}, 32'(edge_err), 32'd0);
        for (w = 1; w < exp_words.size(); w++) begin
            if (w < first_fall_times.size() && w < start_times.size()) begin
                if (delay_before[w])
                    chk_range($sformatf("%s_quiet_before_w%0d", tag, w),
                              first_fall_times[w] - stop_rise_times[w - 1],
                              DLY_C + 4 * Q, DLY_C + 16 * Q);
                else
                    chk_range($sformatf("%s_write_period_w%0d", tag, w),
                              start_times[w] - start_times[w - 1], 124 * Q, 124 * Q + 4);
            end
        end
        check_vec({tag, "_end"}, dv);
    endtask

    initial begin
        int i;
        start = 1'b0; cam_nack = 1'b0; rst_n = 1'b0;
        build_model();
        rv.push_back('{"busy", 0, 8'h00}); rv.push_back('{"done", 1, 8'h00});
        rv.push_back('{"err", 2, 8'h00});  rv.push_back('{"index", 3, 8'h00});
        rv.push_back('{"sioc", 4, 8'h01}); rv.push_back('{"siod_oe", 5, 8'h00});
        rv.push_back('{"cam_rst_n", 6, 8'h01}); rv.push_back('{"cam_pwdn", 7, 8'h00});
        dv.push_back('{"busy", 0, 8'h00}); dv.push_back('{"done", 1, 8'h01});
        dv.push_back('{"err", 2, 8'h00});  dv.push_back('{"index", 3, 8'(exp_end_idx)});
        dv.push_back('{"sioc", 4, 8'h01}); dv.push_back('{"siod_oe", 5, 8'h00});
        dv.push_back('{"cam_rst_n", 6, 8'h01});

        repeat (3) @(negedge clk);
        check_vec("in_reset", rv);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_vec("idle", rv);

        // Full run with ignored start pulses while busy.
        clear_mon();
        repeat ($urandom_range(1, 6)) @(posedge clk);
        pulse_start();
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'd1);
        repeat ($urandom_range(2, 4)) begin
            repeat ($urandom_range(5, 400)) @(negedge clk);
            if (busy) pulse_start();
        end
        wait_idle("run1");
        if (frames.size() > 0) chk("run1_first_word", 32'(frames[0].data), 32'h00421280);
        check_run("run1");

        // Restart from DONE, then reset in the middle of the first byte.
        clear_mon();
        pulse_start();
        @(negedge clk);
        chk("restart_done_cleared", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        for (i = 0; i < BOUND && !(in_frame && nbits >= 3); i++) @(negedge clk);
        chk("midbyte_reached", 32'(in_frame && nbits >= 3), 32'd1);
        repeat ($urandom_range(0, 6)) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_vec("mid_reset", rv);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        pulse_start();
        wait_idle("run2");
        check_run("run2");

        // Camera holding SIOD high through every acknowledge slot.
        clear_mon();
        cam_nack = 1'b1;
        pulse_start();
        wait_idle("run_nack");
`ifdef SCCB_ACK_CHECK_EN
        chk("nack_err", 32'(err), 32'd1);
        chk("nack_done", 32'(done), 32'd0);
        chk("nack_n_stop", 32'(n_stop), 32'd1);
        if (frames.size() > 0) begin
            chk("nack_frame_bits", 32'(frames[0].nbits), 32'd10);
            chk("nack_first_byte", 32'(frames[0].data[8:1]), 32'h42);
        end else begin
            chk("nack_frame_present", 32'(frames.size()), 32'd1);
        end
`else
        chk("noack_done", 32'(done), 32'd1);
        chk("noack_err", 32'(err), 32'd0);
        chk("noack_n_stop", 32'(n_stop), 32'(exp_words.size()));
`endif
        cam_nack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
